// File: rtl/counter_timer_low.sv
// counter_timer_low
//   Low 32-bit word of the chainable counter/timer. Standalone it is a
//   complete up/down timer with reload value; chained it supplies the
//   carry/borrow strobe to the high word and combines with the high word's
//   stop to form the 64-bit terminal condition.
//
//   Optional build macro: COUNTER_TIMER_LOW_PRESCALE_EN
//     Adds a clock prescaler, N = cfg[15:8]; counting advances every N+1
//     clkin cycles. Without it every enabled cycle advances the count.
//
//   Ports
//     clkin, resetn         clock, async active-low reset
//     reg_cfg_we/di/do      CONFIG: [0] enable [1] oneshot [2] updown(1=up)
//                           [3] chain [4] irq_ena ([15:8] prescale option)
//     reg_val_we/di/do      VALUE: reset/terminal value, byte writes
//     reg_dat_we/di/do      DATA: current count, byte writes
//     enable_in, stop_in    from high word: enabled / at terminal
//     strobe                carry (up) / borrow (down) to high word
//     is_offset             carry pending, high word compares count+1
//     stop_out, enable_out  terminal reached / cfg enable
//     irq_out               one-cycle interrupt pulse
module counter_timer_low #(
    parameter int PRESCALE_W = 8
) (
    input  logic        clkin,
    input  logic        resetn,
    input  logic        reg_cfg_we,
    input  logic [31:0] reg_cfg_di,
    output logic [31:0] reg_cfg_do,
    input  logic [3:0]  reg_val_we,
    input  logic [31:0] reg_val_di,
    output logic [31:0] reg_val_do,
    input  logic [3:0]  reg_dat_we,
    input  logic [31:0] reg_dat_di,
    output logic [31:0] reg_dat_do,
    input  logic        enable_in,
    input  logic        stop_in,
    output logic        strobe,
    output logic        is_offset,
    output logic        stop_out,
    output logic        enable_out,
    output logic        irq_out
);

    logic        enable_q, oneshot_q, updown_q, chain_q, irq_ena_q;
    logic [31:0] value_reset_q, value_cur_q;
    logic        stop_q, stop_d_q, irq_q, lastenable_q;

    logic        loc_enable, dat_wr, tick;
    logic        cur_max, cur_zero, cur_one, cur_at_reset;
    logic [31:0] cur_inc, cur_dec;
    logic [4:0]  cfg5;

    assign cfg5       = {irq_ena_q, chain_q, updown_q, oneshot_q, enable_q};
    assign loc_enable = enable_q & (~chain_q | enable_in);
    assign dat_wr     = |reg_dat_we;

    assign cur_inc      = value_cur_q + 32'd1;
    assign cur_dec      = value_cur_q - 32'd1;
    assign cur_max      = &value_cur_q;
    assign cur_zero     = ~|value_cur_q;
    assign cur_one      = (value_cur_q == 32'd1);
    assign cur_at_reset = (value_cur_q == value_reset_q);

`ifdef COUNTER_TIMER_LOW_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, pcnt_q;
    logic [7:0]            ps_rd;
    logic                  unused_cfg;

    assign tick = (pcnt_q == prescale_q);

    always_comb begin
        ps_rd = '0;
        ps_rd[PRESCALE_W-1:0] = prescale_q;
    end

    // Prescaler restarts with the count so the first step after a restart
    // or a DATA write is a full N+1 cycles away.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            prescale_q <= '0;
            pcnt_q     <= '0;
        end else begin
            if (reg_cfg_we) prescale_q <= reg_cfg_di[8 +: PRESCALE_W];
            if (dat_wr || (loc_enable && !lastenable_q)) pcnt_q <= '0;
            else if (loc_enable) pcnt_q <= tick ? '0 : pcnt_q + PRESCALE_W'(1);
        end
    end

    assign reg_cfg_do = {16'b0, ps_rd, 3'b0, cfg5};
    assign unused_cfg = ^{reg_cfg_di[31:16], reg_cfg_di[7:5]};
`else
    logic unused_cfg;

    assign tick       = 1'b1;
    assign reg_cfg_do = {27'b0, cfg5};
    assign unused_cfg = ^reg_cfg_di[31:5];
`endif

    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            {irq_ena_q, chain_q, updown_q, oneshot_q, enable_q} <= '0;
            value_reset_q <= '0;
            value_cur_q   <= '0;
            stop_q        <= 1'b0;
            stop_d_q      <= 1'b0;
            irq_q         <= 1'b0;
            lastenable_q  <= 1'b0;
        end else begin
            lastenable_q <= loc_enable;
            stop_d_q     <= stop_q;

            if (reg_cfg_we)
                {irq_ena_q, chain_q, updown_q, oneshot_q, enable_q} <= reg_cfg_di[4:0];
            for (int b = 0; b < 4; b++)
                if (reg_val_we[b]) value_reset_q[8*b +: 8] <= reg_val_di[8*b +: 8];

            // Rising-edge detect on stop; ~irq_q keeps it to one cycle.
            if (loc_enable)
                irq_q <= irq_ena_q & stop_q & ~stop_d_q & ~irq_q;

            if (dat_wr) begin
                for (int b = 0; b < 4; b++)
                    if (reg_dat_we[b]) value_cur_q[8*b +: 8] <= reg_dat_di[8*b +: 8];
            end else if (!loc_enable) begin
                stop_q <= 1'b0;
            end else if (!lastenable_q) begin
                value_cur_q <= updown_q ? 32'd0 : value_reset_q;
                stop_q      <= 1'b0;
            end else if (tick) begin
                if (updown_q) begin
                    if (chain_q && !stop_in) begin
                        // High word not at terminal: free-running carry chain.
                        value_cur_q <= cur_inc;
                        stop_q      <= 1'b0;
                    end else if (!cur_at_reset) begin
                        value_cur_q <= cur_inc;
                        stop_q      <= ~chain_q & cur_max;
                    end else if (oneshot_q) begin
                        stop_q <= 1'b1;
                    end else if (chain_q && !stop_q) begin
                        // Hold one cycle with stop high so the high word
                        // sees the 64-bit terminal and resets itself.
                        stop_q <= 1'b1;
                    end else begin
                        value_cur_q <= 32'd0;
                        stop_q      <= 1'b0;
                    end
                end else begin
                    if (!cur_zero) begin
                        value_cur_q <= cur_dec;
                        stop_q      <= ~chain_q & cur_one;
                    end else if (chain_q && !stop_in) begin
                        value_cur_q <= 32'hFFFF_FFFF;  // borrow from high word
                        stop_q      <= 1'b0;
                    end else begin
                        stop_q <= oneshot_q | chain_q;
                        if (!oneshot_q) value_cur_q <= value_reset_q;
                    end
                end
            end
        end
    end

    // Same-cycle strobe: high word steps on the edge where the low word wraps.
    assign strobe = loc_enable & chain_q & lastenable_q & ~stop_in & ~stop_q &
                    ~dat_wr & tick & (updown_q ? cur_max : cur_zero);
    assign is_offset = chain_q & updown_q & cur_max;

    assign stop_out   = stop_q;
    assign irq_out    = irq_q;
    assign enable_out = enable_q;
    assign reg_val_do = value_reset_q;
    assign reg_dat_do = value_cur_q;

endmodule

// File: tb/tb_counter_timer_low.sv
module tb_counter_timer_low;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        reg_cfg_we = 1'b0;
    logic [31:0] reg_cfg_di = '0;
    logic [31:0] reg_cfg_do;
    logic [3:0]  reg_val_we = '0;
    logic [31:0] reg_val_di = '0;
    logic [31:0] reg_val_do;
    logic [3:0]  reg_dat_we = '0;
    logic [31:0] reg_dat_di = '0;
    logic [31:0] reg_dat_do;
    logic        enable_in = 1'b0;
    logic        stop_in = 1'b0;
    logic        strobe, is_offset, stop_out, enable_out, irq_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_timer_low dut (
        .clkin(clk), .resetn(resetn),
        .reg_cfg_we(reg_cfg_we), .reg_cfg_di(reg_cfg_di), .reg_cfg_do(reg_cfg_do),
        .reg_val_we(reg_val_we), .reg_val_di(reg_val_di), .reg_val_do(reg_val_do),
        .reg_dat_we(reg_dat_we), .reg_dat_di(reg_dat_di), .reg_dat_do(reg_dat_do),
        .enable_in(enable_in), .stop_in(stop_in),
        .strobe(strobe), .is_offset(is_offset), .stop_out(stop_out),
        .enable_out(enable_out), .irq_out(irq_out)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_en = 0, m_one = 0, m_up = 0, m_chain = 0, m_irqena = 0;
    logic [7:0]  m_ps = 0, m_pc = 0;
    logic [31:0] m_vr = 0, m_vc = 0;
    logic        m_stop = 0, m_stopd = 0, m_irq = 0, m_laste = 0;

    always @(posedge clk or negedge resetn) begin
        logic        le, tk, limited;
        logic [31:0] nvc;
        logic        nstop, nirq;
        logic [7:0]  npc;
        if (!resetn) begin
            {m_en, m_one, m_up, m_chain, m_irqena} <= '0;
            m_ps <= 0; m_pc <= 0; m_vr <= 0; m_vc <= 0;
            m_stop <= 0; m_stopd <= 0; m_irq <= 0; m_laste <= 0;
        end else begin
            le  = m_en && (!m_chain || enable_in);
            tk  = (m_pc == m_ps);
            nvc = m_vc; nstop = m_stop; nirq = m_irq; npc = m_pc;
            if (le) nirq = m_irqena && m_stop && !m_stopd && !m_irq;
            if (reg_dat_we != 0) begin
                for (int b = 0; b < 4; b++)
                    if (reg_dat_we[b]) nvc[8*b +: 8] = reg_dat_di[8*b +: 8];
                npc = 0;
            end else if (!le) begin
                nstop = 0;
            end else if (!m_laste) begin
                nvc = m_up ? 32'd0 : m_vr; nstop = 0; npc = 0;
            end else if (!tk) begin
                npc = m_pc + 8'd1;
            end else begin
                npc = 0;
                // Up count has a ceiling (value_reset) standalone or when the
                // high word is at its terminal; otherwise it wraps freely.
                limited = !m_chain || stop_in;
                if (m_up) begin
                    if (limited && m_vc == m_vr) begin
                        if (m_one || (m_chain && !m_stop)) nstop = 1;
                        else begin nvc = 0; nstop = 0; end
                    end else begin
                        nvc = m_vc + 1;
                        nstop = !m_chain && (nvc == 0);
                    end
                end else begin
                    if (m_vc != 0) begin
                        nvc = m_vc - 1;
                        nstop = !m_chain && (nvc == 0);
                    end else if (m_chain && !stop_in) begin
                        nvc = 32'hFFFF_FFFF; nstop = 0;
                    end else begin
                        nstop = m_one || m_chain;
                        if (!m_one) nvc = m_vr;
                    end
                end
            end
            if (reg_cfg_we) begin
                {m_irqena, m_chain, m_up, m_one, m_en} <= reg_cfg_di[4:0];
`ifdef COUNTER_TIMER_LOW_PRESCALE_EN
                m_ps <= reg_cfg_di[15:8];
`endif
            end
            for (int b = 0; b < 4; b++)
                if (reg_val_we[b]) m_vr[8*b +: 8] <= reg_val_di[8*b +: 8];
            m_vc <= nvc; m_stop <= nstop; m_irq <= nirq; m_pc <= npc;
            m_laste <= le; m_stopd <= m_stop;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic le, xs;
        le = m_en && (!m_chain || enable_in);
        xs = le && m_chain && m_laste && !stop_in && !m_stop && (reg_dat_we == 0) &&
             (m_pc == m_ps) && (m_up ? (m_vc == 32'hFFFF_FFFF) : (m_vc == 0));
        chk("cmp_dat", reg_dat_do, m_vc);
        chk("cmp_val", reg_val_do, m_vr);
        chk("cmp_cfg", reg_cfg_do, {16'b0, m_ps, 3'b0, m_irqena, m_chain, m_up, m_one, m_en});
        chk("cmp_stop", 32'(stop_out), 32'(m_stop));
        chk("cmp_irq", 32'(irq_out), 32'(m_irq));
        chk("cmp_en", 32'(enable_out), 32'(m_en));
        chk("cmp_strobe", 32'(strobe), 32'(xs));
        chk("cmp_offset", 32'(is_offset), 32'(m_chain && m_up && m_vc == 32'hFFFF_FFFF));
    end

    // ---------------- stimulus ----------------
    task automatic sync(); @(posedge clk); #1; endtask
    task automatic wr_cfg(input logic [31:0] v);
        reg_cfg_we = 1; reg_cfg_di = v; sync(); reg_cfg_we = 0;
    endtask
    task automatic wr_val(input logic [31:0] v);
        reg_val_we = 4'hF; reg_val_di = v; sync(); reg_val_we = 0;
    endtask
    task automatic wr_dat(input logic [31:0] v);
        reg_dat_we = 4'hF; reg_dat_di = v; sync(); reg_dat_we = 0;
    endtask

    localparam logic [31:0] T1_VC [7] = '{0, 0, 1, 2, 3, 0, 1};
    localparam logic [31:0] T2_VC [5] = '{2, 1, 0, 0, 0};
    localparam logic [4:0]  T2_ST     = 5'b00111;   // index 0 at MSB
    localparam logic [4:0]  T2_IRQ    = 5'b00010;
    localparam logic [31:0] T4_VC [8] = '{0, 1, 2, 3, 4, 5, 5, 5};
    localparam logic [7:0]  T4_ST     = 8'b00000011;
    localparam logic [31:0] T5_VC [3] = '{1, 0, 32'hFFFF_FFFF};
    localparam logic [2:0]  T5_STB    = 3'b010;

    initial begin
        logic [31:0] choice [6];
        choice = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 32'h2, 32'h0};

        #22 resetn = 1;
        @(negedge clk);
        chk("rst_dat", reg_dat_do, 0);
        chk("rst_cfg", reg_cfg_do, 0);
        chk("rst_stop", 32'(stop_out), 0);
        chk("rst_irq", 32'(irq_out), 0);
        sync();

        // standalone up continuous
        wr_val(3); wr_cfg(32'h05);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("up_cont_vc", reg_dat_do, T1_VC[i]);
            chk("up_cont_stop", 32'(stop_out), 0);
            chk("up_cont_irq", 32'(irq_out), 0);
        end
        sync();

        // standalone down oneshot with irq
        wr_cfg(0); wr_val(2); wr_cfg(32'h13);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("dn_one_vc", reg_dat_do, T2_VC[i]);
            chk("dn_one_stop", 32'(stop_out), 32'(T2_ST[4-i]));
            chk("dn_one_irq", 32'(irq_out), 32'(T2_IRQ[4-i]));
        end
        sync();

        // chained up carry
        wr_cfg(0); enable_in = 1; stop_in = 0; wr_cfg(32'h0D); sync();
        wr_dat(32'hFFFF_FFFE);
        @(negedge clk);
        chk("carry_vc0", reg_dat_do, 32'hFFFF_FFFE);
        chk("carry_stb0", 32'(strobe), 0);
        @(negedge clk);
        chk("carry_off1", 32'(is_offset), 1);
        chk("carry_stb1", 32'(strobe), 1);
        @(negedge clk);
        chk("carry_vc2", reg_dat_do, 0);
        chk("carry_stb2", 32'(strobe), 0);
        sync();

        // chained terminal, oneshot
        wr_cfg(0); wr_val(5); stop_in = 1; wr_cfg(32'h0F);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("term_vc", reg_dat_do, T4_VC[i]);
            chk("term_stop", 32'(stop_out), 32'(T4_ST[7-i]));
            chk("term_stb", 32'(strobe), 0);
        end
        sync();

        // chained down borrow then terminal reload
        wr_cfg(0); wr_val(1); stop_in = 0; wr_cfg(32'h09);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("borrow_vc", reg_dat_do, T5_VC[i]);
            chk("borrow_stb", 32'(strobe), 32'(T5_STB[2-i]));
        end
        sync();
        wr_dat(0); stop_in = 1;
        @(negedge clk);
        chk("dterm_vc0", reg_dat_do, 0);
        chk("dterm_stb0", 32'(strobe), 0);
        @(negedge clk);
        chk("dterm_vc1", reg_dat_do, 1);
        chk("dterm_stop1", 32'(stop_out), 1);
        @(negedge clk);
        chk("dterm_vc2", reg_dat_do, 0);
        chk("dterm_stop2", 32'(stop_out), 0);
        sync();

        // DATA write over a strobe cycle, enable_in drop, restart
        stop_in = 0; wr_cfg(32'h0D); wr_dat(32'hFFFF_FFFF);
        @(negedge clk);
        chk("prio_stb_before", 32'(strobe), 1);
        #1 reg_dat_we = 4'hF; reg_dat_di = 32'h10;
        #1 chk("prio_stb_wr", 32'(strobe), 0);
        sync(); reg_dat_we = 0; enable_in = 0;
        @(negedge clk);
        chk("prio_vc", reg_dat_do, 32'h10);
        @(negedge clk);
        chk("hold_vc", reg_dat_do, 32'h10);
        chk("hold_stop", 32'(stop_out), 0);
        chk("hold_stb", 32'(strobe), 0);
        sync(); enable_in = 1;
        @(negedge clk);
        @(negedge clk);
        chk("restart_vc0", reg_dat_do, 0);
        @(negedge clk);
        chk("restart_vc1", reg_dat_do, 1);

        // async reset mid-operation
        sync(); #2 resetn = 0;
        #1;
        chk("arst_dat", reg_dat_do, 0);
        chk("arst_cfg", reg_cfg_do, 0);
        chk("arst_val", reg_val_do, 0);
        chk("arst_outs", {27'b0, strobe, is_offset, stop_out, enable_out, irq_out}, 0);
        #2 resetn = 1;
        sync();

        // randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            reg_cfg_we = ($urandom_range(0, 40) == 0);
            reg_cfg_di = {$urandom_range(0, 65535), 6'b0, 2'($urandom_range(0, 2)),
                          3'($urandom), 4'($urandom), ($urandom_range(0, 5) != 0)};
            reg_val_we = ($urandom_range(0, 30) == 0) ? 4'($urandom) : 4'h0;
            reg_val_di = $urandom_range(0, 6);
            reg_dat_we = ($urandom_range(0, 25) == 0) ? 4'($urandom) : 4'h0;
            reg_dat_di = ($urandom_range(0, 3) == 0) ? $urandom : choice[$urandom_range(0, 5)];
            if ($urandom_range(0, 30) == 0) enable_in = ~enable_in;
            if ($urandom_range(0, 15) == 0) stop_in = ~stop_in;
            sync();
        end
        reg_cfg_we = 0; reg_val_we = 0; reg_dat_we = 0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_timer_low.md
Name: counter_timer_low

Overview:
- Low 32-bit word of Caravel's chainable counter/timer; also usable standalone.
- In chain mode it supplies the counting side of the chain interface to the high-word block: it drives strobe (carry/borrow) and is_offset (carry-pending).
- It consumes stop_in (high word at terminal) and enable_in (high word enabled). stop_out, enable_out and irq_out serve the 64-bit terminal condition.
- Sits behind the same Wishbone register wrapper as the high word: CONFIG / VALUE / DATA.

Parameters:
- PRESCALE_W, 8, prescaler width; used only with COUNTER_TIMER_LOW_PRESCALE_EN.

Ports:
- clkin  input  1  clock
- resetn  input  1  reset, asynchronous, active-low
- reg_cfg_we  input  1  config write strobe
- reg_cfg_di  input  32  config write data
- reg_cfg_do  output  32  config readback
- reg_val_we  input  4  reset/terminal value byte write enables
- reg_val_di  input  32  value write data
- reg_val_do  output  32  value_reset readback
- reg_dat_we  input  4  current-count byte write enables
- reg_dat_di  input  32  count write data
- reg_dat_do  output  32  value_cur readback
- enable_in  input  1  enable from high word
- stop_in  input  1  high word at terminal
- strobe  output  1  carry (up) / borrow (down) to high word
- is_offset  output  1  carry pending (high word compares count+1)
- stop_out  output  1  terminal reached (64-bit when chained)
- enable_out  output  1  equals cfg enable
- irq_out  output  1  one-cycle interrupt pulse

Behaviour:
- Config bits: [0] enable, [1] oneshot, [2] updown (1 = up), [3] chain, [4] irq_ena. Readback is zero-extended.
- Reset values: all config bits 0, value_reset 0, value_cur 0, stop_out 0, irq_out 0, lastenable 0.
- loc_enable = enable & (chain ? enable_in : 1).
- lastenable is registered loc_enable every cycle.
- Priority per cycle: DATA write > loc_enable==0 (stop_out<=0) > first enabled cycle (lastenable==0) > counting.
- DATA write: per-byte update of value_cur; strobe is forced 0 that cycle.
- First enabled cycle: value_cur <= (updown ? 0 : value_reset); stop_out <= 0.
- Standalone up (chain=0):
  - value_cur==value_reset: oneshot holds with stop_out<=1; continuous sets value_cur<=0, stop_out<=0.
  - Otherwise value_cur+1; stop_out <= (value_cur+1==0).
- Standalone down (chain=0):
  - value_cur==0: oneshot holds with stop_out<=1; continuous reloads value_reset, stop_out<=0.
  - Otherwise value_cur-1; stop_out <= (value_cur-1==0).
- Chained up, stop_in=0: value_cur+1, wrapping 0xFFFFFFFF->0.
- Chained up, stop_in=1 (high at terminal): count up to value_reset.
  - At equality: stop_out<=1.
  - Oneshot holds value.
  - Continuous: value_cur<=0 next cycle, then stop_out<=0. The high word resets itself on this stop.
- Chained down, value_cur==0 and stop_in=0: value_cur<=0xFFFFFFFF (borrow).
- Chained down, value_cur==0 and stop_in=1: terminal; stop_out<=1. Oneshot holds; continuous reloads value_reset.
- Chained down, otherwise: value_cur-1.
- strobe is combinational, asserted only when all hold:
  - loc_enable & chain & lastenable & ~stop_in & ~stop_out & no DATA write;
  - value_cur==0xFFFFFFFF when up, or value_cur==0 when down.
- Timing: strobe is high in the same cycle the low word wraps, so the high word's increment lands on the same edge.
- is_offset is combinational = chain & updown & (value_cur==0xFFFFFFFF).
- irq_out <= irq_ena & stop_out & ~stop_out_d & ~irq_out, evaluated only while loc_enable. It is a single-cycle pulse one cycle after the stop_out rising edge.
- stop_out_d is registered stop_out.
- Clearing enable mid-count: value_cur is held, stop_out<=0, strobe=0. Re-enable restarts from 0 (up) or from value_reset (down).
- Asynchronous reset mid-operation returns all state to the reset values immediately.

Optional Feature:
- Macro: COUNTER_TIMER_LOW_PRESCALE_EN.
- With the macro defined:
  - reg_cfg_di[15:8] is the prescale value N, read back at reg_cfg_do[15:8].
  - An internal PRESCALE_W-bit counter generates a tick every N+1 clkin cycles.
  - Counting steps, strobe and stop evaluation occur only on tick cycles.
  - The prescaler clears on the first enabled cycle and on DATA writes.
  - N=0 is identical to no prescale.
- Without the macro: every enabled cycle is a tick, and cfg bits [15:8] read 0.

Test Plan:
- Standalone up continuous: value_reset=3, cfg=0x05 -> value_cur 0,1,2,3,0; stop_out 0 throughout; irq_out never.
- Standalone down oneshot: value_reset=2, cfg=0x13 -> value_cur 2,1,0 (hold); stop_out rises with value_cur=0; irq_out is a single pulse one cycle later.
- Chained up carry: cfg=0x0D, enable_in=1, stop_in=0, DATA write 0xFFFFFFFE -> is_offset=1 at 0xFFFFFFFF, strobe=1 for exactly that cycle, then value_cur=0 with strobe=0.
- Chained terminal: stop_in=1, value_reset=5, oneshot=1 -> counts 0..5, stop_out=1 and held, strobe never asserted.
- Chained down borrow: cfg=0x09, value_reset=1, stop_in=0 -> 1,0 (strobe=1),0xFFFFFFFF. Then with stop_in=1 at value_cur=0: stop_out=1, reload to 1 (continuous).
- Disable/priority: DATA write 0x10 during a strobe cycle -> value_cur=0x10, strobe=0. Drop enable_in while chained -> count frozen, stop_out=0. Pulse resetn low -> all outputs 0.
